// File: rtl/scale_mux_rr.sv
// rtl/scale_mux_rr.sv - round-robin N:1 valid/ready stream mux with one registered output stage
// Optional packet lock (in_last/out_last) is built when SCALE_MUX_LOCK_EN is defined.
module scale_mux_rr #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 4,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
`ifdef SCALE_MUX_LOCK_EN
   input  logic [NUM_CH-1:0]       in_last,
   output logic                    out_last,
`endif
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]         out_ch,
   input  logic                    out_ready
);

   logic              load;
   logic [CH_W-1:0]   ptr;
   logic [NUM_CH-1:0] req;
   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx;
   logic [WIDTH-1:0]  grant_data;
   logic [CH_W-1:0]   ptr_next;

   // The output stage can take a new beat when empty or when its beat leaves this cycle.
   assign load = !out_valid || out_ready;

`ifdef SCALE_MUX_LOCK_EN
   logic            locked;
   logic [CH_W-1:0] owner;
   logic            grant_last;

   always_comb begin
      req = in_valid;
      if (locked) begin
         req = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (owner == CH_W'(i)) req[i] = in_valid[i];
         end
      end
   end

   always_comb begin
      grant_last = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == CH_W'(i)) grant_last = in_last[i];
      end
   end
`else
   assign req = in_valid;
`endif

   // Rotating search starting at ptr; index wraps explicitly so non-power-of-2 NUM_CH works.
   always_comb begin
      int idx;
      grant_vld  = 1'b0;
      grant_idx  = '0;
      grant_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!grant_vld && req[idx]) begin
            grant_vld  = 1'b1;
            grant_idx  = CH_W'(idx);
            grant_data = in_data[idx*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready[i] = load && grant_vld && (grant_idx == CH_W'(i));
      end
   end

   assign ptr_next = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
`ifdef SCALE_MUX_LOCK_EN
         out_last  <= 1'b0;
         locked    <= 1'b0;
         owner     <= '0;
`endif
      end else if (load) begin
         out_valid <= grant_vld;
         if (grant_vld) begin
            out_data <= grant_data;
            out_ch   <= grant_idx;
`ifdef SCALE_MUX_LOCK_EN
            out_last <= grant_last;
            // Pointer stays put for the whole packet and moves past the owner on its last beat.
            if (!grant_last) begin
               locked <= 1'b1;
               owner  <= grant_idx;
            end else begin
               locked <= 1'b0;
               ptr    <= ptr_next;
            end
`else
            ptr <= ptr_next;
`endif
         end
      end
   end

endmodule

// File: tb/tb_scale_mux_rr.sv
// tb/tb_scale_mux_rr.sv - self-checking bench for scale_mux_rr (NUM_CH=4 and NUM_CH=3 instances)
// Lock checks are included when SCALE_MUX_LOCK_EN is defined.
module tb_scale_mux_rr;

   logic        clk;
   logic        rst_n;

   logic [3:0]  iv4, ir4, il4;
   logic [63:0] id4;
   logic        ov4, ordy4, ol4;
   logic [15:0] od4;
   logic [1:0]  och4;

   logic [2:0]  iv3, ir3, il3;
   logic [47:0] id3;
   logic        ov3, ordy3, ol3;
   logic [15:0] od3;
   logic [1:0]  och3;

   int checks   = 0;
   int failures = 0;

   // Reference state, expressed directly from the arbitration rules
   int          m_ptr, m_och, m_owner;
   bit          m_ov, m_lock, m_ol;
   logic [15:0] m_od;

   scale_mux_rr #(.WIDTH(16), .NUM_CH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv4), .in_data(id4), .in_ready(ir4),
`ifdef SCALE_MUX_LOCK_EN
      .in_last(il4), .out_last(ol4),
`endif
      .out_valid(ov4), .out_data(od4), .out_ch(och4), .out_ready(ordy4)
   );

   scale_mux_rr #(.WIDTH(16), .NUM_CH(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv3), .in_data(id3), .in_ready(ir3),
`ifdef SCALE_MUX_LOCK_EN
      .in_last(il3), .out_last(ol3),
`endif
      .out_valid(ov3), .out_data(od3), .out_ch(och3), .out_ready(ordy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_och = 0; m_owner = 0;
      m_ov = 0; m_lock = 0; m_ol = 0;
      m_od = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      iv4 = 4'($urandom); id4 = {$urandom, $urandom};
      iv3 = 3'($urandom); id3 = 48'({$urandom, $urandom});
      #1;
      chk("rst_out_valid", ov4, 0);
      chk("rst_out_data", od4, 0);
      chk("rst_out_ch", och4, 0);
      chk("rst_out_valid3", ov3, 0);
      iv4 = '0; iv3 = '0;
      #1;
      chk("rst_in_ready", ir4, 0);
      chk("rst_in_ready3", ir3, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One cycle on the 4-channel instance: drive, compare, then advance the model past the edge.
   task automatic step4(input logic [3:0] v, input logic [63:0] d, input logic o, input logic [3:0] l);
      int          w;
      bit          ld;
      logic [3:0]  exp_rdy;
      @(negedge clk);
      iv4 = v; id4 = d; ordy4 = o; il4 = l;
      #1;
      chk("out_valid", ov4, m_ov);
      chk("out_data", od4, m_od);
      chk("out_ch", och4, 64'(m_och));
`ifdef SCALE_MUX_LOCK_EN
      chk("out_last", ol4, m_ol);
`endif
      ld = !m_ov || o;
      w  = -1;
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (m_ptr + k) % 4;
         if (w < 0 && v[c] && (!m_lock || c == m_owner)) w = c;
      end
      exp_rdy = (ld && w >= 0) ? 4'(1 << w) : 4'b0000;
      chk("in_ready", ir4, exp_rdy);
      if (ld) begin
         m_ov = (w >= 0);
         if (w >= 0) begin
            m_od  = d[w*16 +: 16];
            m_och = w;
`ifdef SCALE_MUX_LOCK_EN
            m_ol = l[w];
            if (!l[w]) begin
               m_lock = 1; m_owner = w;
            end else begin
               m_lock = 0; m_ptr = (w + 1) % 4;
            end
`else
            m_ptr = (w + 1) % 4;
`endif
         end
      end
   endtask

   initial begin
      logic [63:0] all_d;
      $timeformat(-9, 0, " ns", 8);
      rst_n = 1'b0;
      iv4 = '0; id4 = '0; ordy4 = 1'b0; il4 = '1;
      iv3 = '0; id3 = '0; ordy3 = 1'b0; il3 = '1;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      // Single beat from channel 2
      step4(4'b0100, 64'h0000_A5A5_0000_0000, 1'b1, 4'hF);
      step4(4'b0000, 64'h0, 1'b1, 4'hF);
      step4(4'b0000, 64'h0, 1'b1, 4'hF);

      // All channels valid, full rate, then a 5-cycle stall and release
      do_reset();
      all_d = 64'h4444_3333_2222_1111;
      for (int i = 0; i < 6; i++) step4(4'b1111, all_d + 64'(i), 1'b1, 4'hF);
      for (int i = 0; i < 5; i++) step4(4'b1111, {$urandom, $urandom}, 1'b0, 4'hF);
      for (int i = 0; i < 5; i++) step4(4'b1111, all_d, 1'b1, 4'hF);
      step4(4'b0000, 64'h0, 1'b1, 4'hF);

`ifdef SCALE_MUX_LOCK_EN
      // Channel 1 packet of 3 beats holds off a continuously valid channel 0
      do_reset();
      step4(4'b0001, 64'h0000_0000_0000_00C0, 1'b1, 4'hF);
      step4(4'b0011, 64'h0000_0000_0B01_00C1, 1'b1, 4'h0);
      step4(4'b0011, 64'h0000_0000_0B02_00C2, 1'b1, 4'h0);
      step4(4'b0011, 64'h0000_0000_0B03_00C3, 1'b1, 4'h2);
      step4(4'b0011, 64'h0000_0000_0B04_00C4, 1'b1, 4'hF);
      step4(4'b0000, 64'h0, 1'b1, 4'hF);
`endif

      // Randomized traffic with random backpressure
      for (int i = 0; i < 300; i++)
         step4(4'($urandom), {$urandom, $urandom}, ($urandom % 4) != 0, 4'($urandom));
      step4(4'b0000, 64'h0, 1'b1, 4'hF);

      // Held beat is dropped as soon as reset asserts, without waiting for a clock edge
      step4(4'b0010, 64'h0000_0000_BEEF_0000, 1'b0, 4'hF);
      step4(4'b0000, 64'h0, 1'b0, 4'hF);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", ov4, 0);
      chk("async_rst_out_data", od4, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      iv4 = '0;

      // Three-channel wrap: ch2 first, then ch0 before ch1
      @(negedge clk);
      iv3 = 3'b100; id3 = 48'h3333_2222_1111; ordy3 = 1'b1;
      #1;
      chk("nch3_ready_ch2", ir3, 3'b100);
      @(negedge clk);
      iv3 = 3'b011;
      #1;
      chk("nch3_out_ch_2", och3, 2);
      chk("nch3_out_data_2", od3, 16'h3333);
      chk("nch3_ready_wrap", ir3, 3'b001);
      @(negedge clk);
      #1;
      chk("nch3_out_ch_0", och3, 0);
      chk("nch3_out_data_0", od3, 16'h1111);
      chk("nch3_ready_ch1", ir3, 3'b010);
      @(negedge clk);
      iv3 = 3'b000;
      #1;
      chk("nch3_out_ch_1", och3, 1);
      chk("nch3_out_data_1", od3, 16'h2222);
      @(negedge clk);
      #1;
      chk("nch3_out_valid_idle", ov3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
